// File: rtl/stq_pkg.sv
// Shared store-queue constants and index/data types.
package stq_pkg;
    localparam int STQ_DEPTH   = 64;
    localparam int STQ_AW      = $clog2(STQ_DEPTH);
    localparam int STQ_ADATA_W = 5;

    typedef logic [STQ_AW-1:0]      wq_t;
    typedef logic [STQ_ADATA_W-1:0] adata_t;
endpackage

// File: rtl/stq_popcnt.sv
// Combinational population count of an N-bit vector into $clog2(N)+1 bits.
module stq_popcnt #(
    parameter int N = 64
) (
    input  logic [N-1:0]         vec,
    output logic [$clog2(N):0]   cnt
);
    localparam int CW = $clog2(N) + 1;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) cnt = cnt + CW'(vec[i]);
    end
endmodule

// File: rtl/stq_adata_mp.sv
// Multi-port WQ-indexed adata side table with valid tracking, occupancy count and collision flag.
// Optional same-cycle write-to-read bypass enabled by defining STQ_ADATA_BYPASS_EN.
module stq_adata_mp
    import stq_pkg::*;
#(
    parameter int DEPTH = STQ_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = STQ_ADATA_W,
    parameter int NWR   = 2,
    parameter int NRD   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wrt_en,
    input  logic [NWR*AW-1:0] wrt_WQ,
    input  logic [NWR*DW-1:0] wrt_adata,
    input  logic [NRD*AW-1:0] upd_WQ,
    output logic [NRD*DW-1:0] upd_adata,
    output logic [NRD-1:0]    upd_vld,
    input  logic              inv_en,
    input  logic [AW-1:0]     inv_WQ,
    input  logic              flush,
    output logic [AW:0]       vld_cnt,
    output logic              collide
);
    logic [DW-1:0]             mem [DEPTH];
    logic [DEPTH-1:0]          vld, vld_nxt;
    logic [AW:0]               cnt_nxt;
    logic                      collide_nxt;
    logic [NWR-1:0][AW-1:0]    wq;
    logic [NWR-1:0][DW-1:0]    wd;
    logic [NRD-1:0][AW-1:0]    rq;
    logic [NRD-1:0][DW-1:0]    rd;
    logic [NRD-1:0]            rv;

    assign wq        = wrt_WQ;
    assign wd        = wrt_adata;
    assign rq        = upd_WQ;
    assign upd_adata = rd;
    assign upd_vld   = rv;

    // Flush, then invalidate, then writes: a write always leaves its entry valid.
    always_comb begin
        vld_nxt = flush ? '0 : vld;
        if (inv_en) vld_nxt[inv_WQ] = 1'b0;
        for (int p = 0; p < NWR; p++)
            if (wrt_en[p]) vld_nxt[wq[p]] = 1'b1;
    end

    always_comb begin
        collide_nxt = 1'b0;
        for (int p = 0; p < NWR; p++)
            for (int q = p + 1; q < NWR; q++)
                if (wrt_en[p] && wrt_en[q] && wq[p] == wq[q]) collide_nxt = 1'b1;
    end

    // Descending port order so port 0's assignment lands last and wins.
    always_ff @(posedge clk) begin
        for (int p = NWR - 1; p >= 0; p--)
            if (wrt_en[p]) mem[wq[p]] <= wd[p];
    end

    stq_popcnt #(.N(DEPTH)) u_popcnt (
        .vec (vld_nxt),
        .cnt (cnt_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld     <= '0;
            vld_cnt <= '0;
            collide <= 1'b0;
        end else begin
            vld     <= vld_nxt;
            vld_cnt <= cnt_nxt;
            collide <= collide_nxt;
        end
    end

    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rd[r] = mem[rq[r]];
            rv[r] = vld[rq[r]];
`ifdef STQ_ADATA_BYPASS_EN
            for (int p = NWR - 1; p >= 0; p--)
                if (wrt_en[p] && wq[p] == rq[r]) begin
                    rd[r] = wd[p];
                    rv[r] = 1'b1;
                end
`endif
            if (rst) rv[r] = 1'b0;
        end
    end
endmodule
